// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Each line holds one word. Read misses refill from a byte-write BRAM port.
// Writes always go through to memory and update a line only if it is already
// cached.
module dcache_wt_ctrl #(
    parameter int ADDR_WIDTH  = 11,
    parameter int INDEX_WIDTH = 6,
    parameter int NUM_COL     = 4,
    parameter int COL_WIDTH   = 8,
    localparam int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [NUM_COL-1:0]    req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_en,
    output logic [NUM_COL-1:0]    mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
    localparam int LINES     = 2 ** INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;

    state_t                  state, state_next;
    logic [NUM_COL-1:0]      lat_we;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;

    logic [LINES-1:0]        valid;
    logic [TAG_WIDTH-1:0]    tag_ram  [LINES];
    logic [DATA_WIDTH-1:0]   data_ram [LINES];

    logic [INDEX_WIDTH-1:0]  index;
    logic [TAG_WIDTH-1:0]    tag;
    logic                    hit;
    logic                    is_write;
    logic                    accept;
    logic                    do_hit_cnt;
    logic                    do_miss_cnt;
    logic                    do_fill;
    logic                    do_wr_hit;

    assign index    = lat_addr[INDEX_WIDTH-1:0];
    assign tag      = lat_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign hit      = valid[index] && (tag_ram[index] == tag);
    assign is_write = |lat_we;

    // Reset wins over everything, so nothing is accepted while it is high.
    assign req_ready = (state == IDLE) && !flush && !rst;
    assign accept    = req_valid && req_ready;

    // The memory address and write data always come from the latched request;
    // they only matter while mem_en is high.
    assign mem_addr = lat_addr;
    assign mem_din  = lat_wdata;

    // Next state, response/memory strobes and bookkeeping enables.
    always_comb begin
        state_next  = state;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        mem_en      = 1'b0;
        mem_we      = '0;
        do_hit_cnt  = 1'b0;
        do_miss_cnt = 1'b0;
        do_fill     = 1'b0;
        do_wr_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (is_write) begin
                    mem_en     = 1'b1;
                    mem_we     = lat_we;
                    rsp_valid  = 1'b1;
                    do_wr_hit  = hit;
                    state_next = IDLE;
                end else if (hit) begin
                    rsp_valid  = 1'b1;
                    rsp_rdata  = data_ram[index];
                    do_hit_cnt = 1'b1;
                    state_next = IDLE;
                end else begin
                    mem_en      = 1'b1;
                    do_miss_cnt = 1'b1;
                    state_next  = FILL;
                end
            end
            FILL: begin
                rsp_valid  = 1'b1;
                rsp_rdata  = mem_dout;
                do_fill    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // An in-flight request is abandoned silently when reset hits.
        if (rst) begin
            state_next  = IDLE;
            rsp_valid   = 1'b0;
            mem_en      = 1'b0;
            mem_we      = '0;
            do_hit_cnt  = 1'b0;
            do_miss_cnt = 1'b0;
            do_fill     = 1'b0;
            do_wr_hit   = 1'b0;
        end
    end

    // State, valid bits and saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_next;
            if (flush && state == IDLE) valid <= '0;
            else if (do_fill)           valid[index] <= 1'b1;
            if (do_hit_cnt && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
            if (do_miss_cnt && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end

    // Request latch; only loaded on a handshake.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Line storage: refill on a read miss, lane-merge on a write hit.
    // Not reset; the valid bits guard stale contents.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            data_ram[index] <= mem_dout;
            tag_ram[index]  <= tag;
        end else if (do_wr_hit) begin
            for (int i = 0; i < NUM_COL; i++) begin
                if (lat_we[i])
                    data_ram[index][i*COL_WIDTH +: COL_WIDTH] <= lat_wdata[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_dcache_wt_ctrl.sv
// Bench for dcache_wt_ctrl: directed table, hand-written flush/reset
// sequences, then random traffic against a simple cache/memory model.
module tb_dcache_wt_ctrl;

    localparam int AW = 11;
    localparam int IW = 6;
    localparam int NC = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic [NC-1:0] req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_en;
    logic [NC-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;

    dcache_wt_ctrl #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .NUM_COL(NC), .COL_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Backing BRAM seen by the DUT.
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == '0) mem_dout <= ram[mem_addr];
            else for (int i = 0; i < NC; i++)
                if (mem_we[i]) ram[mem_addr][i*8 +: 8] <= mem_din[i*8 +: 8];
        end
    end

    // Reference model: memory contents as the CPU sees them, plus which
    // address each cache slot currently holds.
    logic [DW-1:0] ref_ram [2**AW];
    logic [AW-1:0] m_addr  [2**IW];
    bit   [2**IW-1:0] m_valid;
    int   m_hits, m_misses;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = '0;
    endtask

    // One complete request, starting and ending at a negedge.
    task automatic do_req(input logic [NC-1:0] we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output logic obs_rsp1,
                          output logic [DW-1:0] obs_rd);
        int  idx;
        bit  mhit;
        idx  = int'(addr[IW-1:0]);
        mhit = m_valid[idx] && (m_addr[idx] == addr);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        obs_rsp1 = rsp_valid;
        obs_rd   = rsp_rdata;
        if (we != '0) begin
            chk("wr_rsp", rsp_valid, 1);
            chk("wr_mem_en", mem_en, 1);
            chk("wr_mem_we", mem_we, we);
            chk("wr_mem_addr", mem_addr, addr);
            chk("wr_mem_din", mem_din, wd);
            for (int i = 0; i < NC; i++)
                if (we[i]) ref_ram[addr][i*8 +: 8] = wd[i*8 +: 8];
        end else if (mhit) begin
            chk("hit_rsp", rsp_valid, 1);
            chk("hit_mem_en", mem_en, 0);
            chk("hit_rdata", rsp_rdata, ref_ram[addr]);
            if (m_hits != 65535) m_hits++;
        end else begin
            chk("miss_rsp_early", rsp_valid, 0);
            chk("miss_mem_en", mem_en, 1);
            chk("miss_mem_we", mem_we, 0);
            chk("miss_mem_addr", mem_addr, addr);
            @(negedge clk);
            chk("fill_rsp", rsp_valid, 1);
            chk("fill_rdata", rsp_rdata, ref_ram[addr]);
            chk("fill_mem_en", mem_en, 0);
            obs_rd = rsp_rdata;
            m_valid[idx] = 1'b1;
            m_addr[idx]  = addr;
            if (m_misses != 65535) m_misses++;
        end
        @(negedge clk);
        chk("back_idle_rsp", rsp_valid, 0);
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
    endtask

    typedef struct {
        logic [NC-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rsp1;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic          r1;
        logic [DW-1:0] rd;

        for (int i = 0; i < 2**AW; i++) begin
            ram[i] = $urandom;
        end
        ram[11'h040] = 32'hDEADBEEF;
        ram[11'h080] = 32'h12345678;
        ram[11'h100] = 32'hCAFEF00D;
        for (int i = 0; i < 2**AW; i++) ref_ram[i] = ram[i];
        m_valid = '0; m_hits = 0; m_misses = 0;

        vecs[0] = '{4'b0000, 11'h040, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[1] = '{4'b0000, 11'h040, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[2] = '{4'b0010, 11'h040, 32'h0000AA00, 1'b1, 32'h0};
        vecs[3] = '{4'b0000, 11'h040, 32'h0,        1'b1, 32'hDEADAAEF};
        vecs[4] = '{4'b0000, 11'h080, 32'h0,        1'b0, 32'h12345678};
        vecs[5] = '{4'b0000, 11'h040, 32'h0,        1'b0, 32'hDEADAAEF};
        vecs[6] = '{4'b0000, 11'h080, 32'h0,        1'b0, 32'h12345678};

        // Reset
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0;
        req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);

        // Directed table
        for (int v = 0; v < 7; v++) begin
            do_req(vecs[v].we, vecs[v].addr, vecs[v].wdata, r1, rd);
            chk($sformatf("tbl%0d_rsp1", v), r1, vecs[v].rsp1);
            if (vecs[v].we == '0) chk($sformatf("tbl%0d_rdata", v), rd, vecs[v].rdata);
        end
        chk("tbl_hits", hit_count, 2);
        chk("tbl_misses", miss_count, 4);

        // Flush pulse with a competing request: nothing accepted, 0x080 misses after
        flush = 1'b1; req_valid = 1'b1; req_we = '0; req_addr = 11'h080;
        #1 chk("flush_ready", req_ready, 0);
        @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
        model_clear();
        @(negedge clk);
        chk("flush_no_rsp", rsp_valid, 0);
        chk("flush_no_mem_en", mem_en, 0);
        do_req('0, 11'h080, '0, r1, rd);
        chk("flush_then_miss", r1, 0);

        // Reset while in FILL: no response, line not installed
        req_valid = 1'b1; req_we = '0; req_addr = 11'h100;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstfill_lookup_mem_en", mem_en, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rstfill_no_rsp", rsp_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        model_clear(); m_hits = 0; m_misses = 0;
        @(negedge clk);
        chk("rstfill_rsp_after", rsp_valid, 0);
        chk("rstfill_hits", hit_count, 0);
        chk("rstfill_misses", miss_count, 0);
        do_req('0, 11'h100, '0, r1, rd);
        chk("rstfill_then_miss", r1, 0);
        chk("rstfill_rdata", rd, 32'hCAFEF00D);

        // Random traffic on a few colliding addresses
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] a;
            logic [NC-1:0] w;
            a = AW'($urandom_range(0, 3) * 64 + $urandom_range(0, 3));
            w = ($urandom_range(0, 1) == 0) ? '0 : NC'($urandom_range(1, 15));
            if ($urandom_range(0, 19) == 0) begin
                flush = 1'b1;
                @(posedge clk); #1 flush = 1'b0;
                model_clear();
                @(negedge clk);
            end
            do_req(w, a, $urandom, r1, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
